// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must hold values 0..WIDTH
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_sub_cell.sv
// Combinational full-subtractor cell: x = a - b - c (difference bit), y = borrow out.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic x,
    output logic y
);

    assign x = a ^ b ^ c;
    assign y = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Optional macro SERIAL_SUB_OVF_EN adds a two's-complement overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_out_valid;
    logic             r_ovf;

    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_a_next;

    full_sub_cell u_cell (
        .a (r_a[0]),
        .b (r_b[0]),
        .c (r_br),
        .x (w_d),
        .y (w_br_next)
    );

    // Difference bits fill the minuend register from the MSB as its bits are consumed,
    // so after WIDTH shifts it holds the full result.
    if (WIDTH == 1) begin : g_w1
        assign w_a_next = w_d;
    end else begin : g_wn
        assign w_a_next = {w_d, r_a[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_br        <= 1'b0;
            r_cnt       <= '0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bin;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a   <= w_a_next;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_diff      <= w_a_next;
                        r_bout      <= w_br_next;
                        r_ovf       <= r_br ^ w_br_next;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign bout      = r_bout;

`ifdef SERIAL_SUB_OVF_EN
    assign ovf = r_ovf;
`else
    logic w_ovf_unused;
    assign w_ovf_unused = r_ovf;
`endif

endmodule
